// File: rtl/jtframe_mister_ddr_dump.sv
// Packs a core byte stream into 64-bit words, buffers one burst and writes it to DDR3
// at BASE<<25 through the MiSTer DDRAM Avalon port. Optional checksum: JTFRAME_DDR_DUMP_CHECKSUM_EN.
module jtframe_mister_ddr_dump #(
  parameter int         BW   = 7,
  parameter logic [3:0] BASE = 4'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic        din_we,
  input  logic [7:0]  din,
  output logic        din_wait,
  output logic        done,
  output logic [26:0] byte_cnt,
  input  logic        ddram_busy,
  output logic [7:0]  ddram_burstcnt,
  output logic [28:0] ddram_addr,
  output logic [63:0] ddram_din,
  output logic [7:0]  ddram_be,
  output logic        ddram_we
`ifdef JTFRAME_DDR_DUMP_CHECKSUM_EN
  ,
  output logic [15:0] chk
`endif
);
  localparam int PW = 25 - BW;
  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] PREP  = 2'd1;
  localparam logic [1:0] BURST = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [26:0]   byte_cnt_q, byte_cnt_d;
  logic [PW-1:0] page_q, page_d;
  logic [63:0]   word_q, word_d;
  logic [7:0]    lane_mask_q, lane_mask_d;
  logic [7:0]    last_mask_q, last_mask_d;
  logic [BW:0]   used_q, used_d;
  logic          partial_q, partial_d;
  logic          from_flush_q, from_flush_d;
  logic [BW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    burstcnt_q, burstcnt_d;
  logic          we_q, we_d;
  logic [63:0]   rd_data_q;
  logic [63:0]   mem [2**BW];

  logic          accept, page_full, mem_we, word_acc, last_idx;
  logic [2:0]    lane;
  logic [26:0]   cnt_n;
  logic [63:0]   word_n;
  logic [7:0]    mask_n;
  logic [BW-1:0] rd_addr;

  // start wins over a simultaneous byte: the session restarts from an empty page
  assign accept    = (state_q == FILL) && din_we && !start;
  assign lane      = byte_cnt_q[2:0];
  assign cnt_n     = byte_cnt_q + 27'(accept);
  assign page_full = accept && (&byte_cnt_q[BW+2:0]);
  assign mem_we    = (state_q == FILL) && !start &&
                     ((accept && lane == 3'd7) || (flush && cnt_n[2:0] != 3'd0));
  assign word_acc  = we_q && !ddram_busy;
  assign last_idx  = ({1'b0, rd_ptr_q} + (BW+1)'(1)) == used_q;
  // Address the word to show next cycle; holding it while busy keeps ddram_din stable
  assign rd_addr   = (state_q == BURST) ? rd_ptr_q + BW'(word_acc) : '0;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    word_n = word_q;
    mask_n = lane_mask_q;
    if (accept) begin
      word_n[{lane, 3'b000} +: 8] = din;
      mask_n[lane]                = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    page_d       = page_q;
    word_d       = word_q;
    lane_mask_d  = lane_mask_q;
    last_mask_d  = last_mask_q;
    used_d       = used_q;
    partial_d    = partial_q;
    from_flush_d = from_flush_q;
    rd_ptr_d     = rd_ptr_q;
    burstcnt_d   = burstcnt_q;
    we_d         = we_q;
    case (state_q)
      FILL: begin
        if (start) begin
          byte_cnt_d  = '0;
          page_d      = '0;
          lane_mask_d = '0;
        end else begin
          byte_cnt_d  = cnt_n;
          word_d      = word_n;
          lane_mask_d = (accept && lane == 3'd7) ? 8'h00 : mask_n;
          if (page_full) begin
            state_d      = PREP;
            used_d       = {1'b1, {BW{1'b0}}};
            partial_d    = 1'b0;
            from_flush_d = flush;
          end else if (flush) begin
            from_flush_d = 1'b1;
            if (cnt_n[BW+2:0] == '0) begin
              state_d = DONE;
            end else begin
              state_d     = PREP;
              used_d      = {1'b0, cnt_n[BW+2:3]} + (BW+1)'(cnt_n[2:0] != 3'd0);
              partial_d   = cnt_n[2:0] != 3'd0;
              last_mask_d = mask_n;
            end
          end
        end
      end
      PREP: begin
        rd_ptr_d   = '0;
        burstcnt_d = 8'(used_q);
        we_d       = 1'b1;
        state_d    = BURST;
      end
      BURST: begin
        if (word_acc) rd_ptr_d = rd_ptr_q + BW'(1);
        if (word_acc && last_idx) begin
          we_d        = 1'b0;
          page_d      = page_q + PW'(1);
          lane_mask_d = '0;
          state_d     = from_flush_q ? DONE : FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: the buffer array carries no reset; only its registered read port does.
  always_ff @(posedge clk) begin
    if (mem_we) mem[byte_cnt_q[BW+2:3]] <= word_n;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      byte_cnt_q   <= '0;
      page_q       <= '0;
      word_q       <= '0;
      lane_mask_q  <= '0;
      last_mask_q  <= '0;
      used_q       <= '0;
      partial_q    <= 1'b0;
      from_flush_q <= 1'b0;
      rd_ptr_q     <= '0;
      burstcnt_q   <= '0;
      we_q         <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      page_q       <= page_d;
      word_q       <= word_d;
      lane_mask_q  <= lane_mask_d;
      last_mask_q  <= last_mask_d;
      used_q       <= used_d;
      partial_q    <= partial_d;
      from_flush_q <= from_flush_d;
      rd_ptr_q     <= rd_ptr_d;
      burstcnt_q   <= burstcnt_d;
      we_q         <= we_d;
      rd_data_q    <= mem[rd_addr];
    end
  end

`ifdef JTFRAME_DDR_DUMP_CHECKSUM_EN
  logic [15:0] chk_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            chk_q <= '0;
    else if (state_q == FILL && start)  chk_q <= '0;
    else if (accept)                    chk_q <= chk_q + 16'(din);
  end
  assign chk = chk_q;
`endif

  assign din_wait       = state_q != FILL;
  assign done           = state_q == DONE;
  assign byte_cnt       = byte_cnt_q;
  assign ddram_we       = we_q;
  assign ddram_din      = rd_data_q;
  assign ddram_burstcnt = burstcnt_q;
  assign ddram_addr     = {BASE, page_q, {BW{1'b0}}};
  assign ddram_be       = (state_q == BURST && partial_q && last_idx) ? last_mask_q : 8'hFF;

endmodule

// File: tb/tb_jtframe_mister_ddr_dump.sv
// Self-checking bench for jtframe_mister_ddr_dump: table of dump sessions, hand-written
// latency/reset sequences and randomized sessions checked against a byte-level model.
module tb_jtframe_mister_ddr_dump;
  localparam int BW         = 7;
  localparam int PAGE_BYTES = 8 << BW;
  localparam int PAGES      = 1 << (25 - BW);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, flush = 1'b0, din_we = 1'b0, ddram_busy = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        din_wait, done, ddram_we;
  logic [26:0] byte_cnt;
  logic [7:0]  ddram_burstcnt, ddram_be;
  logic [28:0] ddram_addr;
  logic [63:0] ddram_din;
`ifdef JTFRAME_DDR_DUMP_CHECKSUM_EN
  logic [15:0] chk;
`endif

  jtframe_mister_ddr_dump #(.BW(BW), .BASE(4'd3)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .din_we(din_we), .din(din),
    .din_wait(din_wait), .done(done), .byte_cnt(byte_cnt), .ddram_busy(ddram_busy),
    .ddram_burstcnt(ddram_burstcnt), .ddram_addr(ddram_addr), .ddram_din(ddram_din),
    .ddram_be(ddram_be), .ddram_we(ddram_we)
`ifdef JTFRAME_DDR_DUMP_CHECKSUM_EN
    , .chk(chk)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout/unexpected event, required normal completion (t=%0t)", name, $time);
  endtask

  function automatic logic [63:0] be_mask(input logic [7:0] be);
    logic [63:0] m;
    for (int k = 0; k < 8; k++) m[8*k +: 8] = {8{be[k]}};
    return m;
  endfunction

  // ---------------- reference model: bytes of the current page and expected writes
  typedef struct {
    logic [28:0] addr;
    logic [7:0]  bc;
    logic [63:0] data;
    logic [7:0]  be;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  pend[$];
  int          m_page, m_cnt, m_done, m_words;
  logic [15:0] m_chk;

  function automatic void model_emit();
    int n  = pend.size();
    int nw = (n + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      wr_t e;
      e.addr = 29'h0600_0000 + 29'(m_page * (1 << BW));
      e.bc   = 8'(nw);
      e.data = '0;
      e.be   = '0;
      for (int k = 0; k < 8; k++)
        if (8*w + k < n) begin
          e.data[8*k +: 8] = pend[8*w + k];
          e.be[k]          = 1'b1;
        end
      exp_q.push_back(e);
    end
    m_words += nw;
    m_page = (m_page + 1) % PAGES;
    pend.delete();
  endfunction

  function automatic void model_push(input logic [7:0] b);
    pend.push_back(b);
    m_cnt++;
    m_chk = m_chk + 16'(b);
    if (pend.size() == PAGE_BYTES) model_emit();
  endfunction

  function automatic void model_flush();
    if (pend.size() > 0) model_emit();
    m_done++;
  endfunction

  function automatic void model_start();
    pend.delete();
    m_page = 0;
    m_cnt  = 0;
    m_chk  = '0;
  endfunction

  // ---------------- bus monitor (samples on the falling edge)
  int          mon_done, mon_words, mon_bursts, mon_wib, mon_we_cycles;
  logic [7:0]  mon_last_bc, mon_last_be;
  logic [63:0] mon_first_data;
  bit          mon_first_seen;
  logic [15:0] mon_chk;
  bit          stall_q;
  logic [63:0] stall_din;
  logic [7:0]  stall_be;
  wr_t         mon_e;

  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
      mon_wib = 0;
    end else begin
      if (stall_q) begin
        check("hold_we", 64'(ddram_we), 64'(1));
        check("hold_din", ddram_din, stall_din);
        check("hold_be", 64'(ddram_be), 64'(stall_be));
      end
      if (ddram_we) mon_we_cycles++;
      if (ddram_we && !ddram_busy) begin
        if (exp_q.size() == 0) fail("unexpected_write");
        else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 64'(ddram_addr), 64'(mon_e.addr));
          check("wr_burstcnt", 64'(ddram_burstcnt), 64'(mon_e.bc));
          check("wr_be", 64'(ddram_be), 64'(mon_e.be));
          check("wr_data", ddram_din & be_mask(mon_e.be), mon_e.data & be_mask(mon_e.be));
        end
        if (!mon_first_seen) begin
          mon_first_data = ddram_din;
          mon_first_seen = 1'b1;
        end
        if (mon_wib == 0) mon_bursts++;
        mon_wib++;
        if (mon_wib == int'(ddram_burstcnt)) mon_wib = 0;
        mon_words++;
        mon_last_bc = ddram_burstcnt;
        mon_last_be = ddram_be;
      end
      stall_q   = ddram_we && ddram_busy;
      stall_din = ddram_din;
      stall_be  = ddram_be;
      if (done) begin
        mon_done++;
`ifdef JTFRAME_DDR_DUMP_CHECKSUM_EN
        mon_chk = chk;
`endif
      end
    end
  end

  bit busy_rand = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    ddram_busy = busy_rand && ($urandom_range(0, 1) == 1);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks (all start and end at posedge+1)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (din_wait && guard < 5000) begin
      tick();
      guard++;
    end
    if (din_wait) fail("ready_timeout");
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_flush);
    wait_ready();
    din    = b;
    din_we = 1'b1;
    flush  = with_flush;
    model_push(b);
    if (with_flush) model_flush();
    tick();
    din_we = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic send_flush();
    wait_ready();
    flush = 1'b1;
    model_flush();
    tick();
    flush = 1'b0;
  endtask

  task automatic do_start();
    wait_ready();
    start = 1'b1;
    model_start();
    tick();
    start = 1'b0;
  endtask

  task automatic clear_counts();
    mon_done = 0; mon_words = 0; mon_bursts = 0; mon_we_cycles = 0;
    mon_first_seen = 1'b0; mon_last_bc = '0; mon_last_be = '0;
    m_done = 0; m_words = 0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    repeat (3) tick();
    while ((din_wait || exp_q.size() != 0) && guard < 5000) begin
      tick();
      guard++;
    end
    if (guard >= 5000) fail("idle_timeout");
    repeat (2) tick();
  endtask

  task automatic check_session(input string tag);
    check({tag, "_words"}, 64'(mon_words), 64'(m_words));
    check({tag, "_byte_cnt"}, 64'(byte_cnt), 64'(m_cnt));
    check({tag, "_done"}, 64'(mon_done), 64'(m_done));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, 64'(ddram_we), 64'(0));
    check({tag, "_din_wait"}, 64'(din_wait), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_byte_cnt"}, 64'(byte_cnt), 64'(0));
    check({tag, "_burstcnt"}, 64'(ddram_burstcnt), 64'(0));
    check({tag, "_be"}, 64'(ddram_be), 64'(8'hFF));
    check({tag, "_ddram_din"}, ddram_din, 64'(0));
    check({tag, "_addr"}, 64'(ddram_addr), 64'(29'h0600_0000));
  endtask

  // fmode: 0 = no flush, 1 = flush after the bytes, 2 = flush together with the last byte
  typedef struct {
    int         n;
    int         fmode;
    int         bursts;
    int         last_bc;
    logic [7:0] last_be;
    int         bcnt;
    int         dn;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1024, 0, 1, 128, 8'hFF, 1024, 0};
    vecs[1] = '{2051, 1, 3,   1, 8'h07, 2051, 1};
    vecs[2] = '{1024, 1, 1, 128, 8'hFF, 1024, 1};
    vecs[3] = '{  13, 2, 1,   2, 8'h1F,   13, 1};
    vecs[4] = '{   0, 1, 0,   0, 8'h00,    0, 1};
    vecs[5] = '{1024, 2, 1, 128, 8'hFF, 1024, 1};
    vecs[6] = '{   8, 1, 1,   1, 8'hFF,    8, 1};

    model_start();
    clear_counts();
    #20;
    check_reset_outputs("reset");
    @(posedge clk);
    #2;
    rst = 1'b0;
    tick();

    // ---- table-driven sessions, bytes 0x00..0xFF repeating
    for (int i = 0; i < 7; i++) begin
      do_start();
      clear_counts();
      for (int j = 0; j < vecs[i].n; j++)
        send_byte(8'(j), vecs[i].fmode == 2 && j == vecs[i].n - 1);
      if (vecs[i].fmode == 1) send_flush();
      wait_idle();
      check($sformatf("vec%0d_bursts", i), 64'(mon_bursts), 64'(vecs[i].bursts));
      if (vecs[i].bursts > 0) begin
        check($sformatf("vec%0d_last_bc", i), 64'(mon_last_bc), 64'(vecs[i].last_bc));
        check($sformatf("vec%0d_last_be", i), 64'(mon_last_be), 64'(vecs[i].last_be));
      end
      check($sformatf("vec%0d_byte_cnt", i), 64'(byte_cnt), 64'(vecs[i].bcnt));
      check($sformatf("vec%0d_done", i), 64'(mon_done), 64'(vecs[i].dn));
      check_session($sformatf("vec%0d_model", i));
      if (i == 0) begin
        check("vec0_word0", mon_first_data, 64'h0706050403020100);
        check("vec0_we_cycles", 64'(mon_we_cycles), 64'(128));
      end
    end

    // ---- latency, dropped bytes while waiting, start ignored mid-burst
    do_start();
    clear_counts();
    for (int j = 0; j < PAGE_BYTES - 1; j++) send_byte(8'(j * 3), 1'b0);
    din    = 8'hEE;
    din_we = 1'b1;
    model_push(8'hEE);
    tick();
    din_we = 1'b0;
    @(negedge clk);
    check("lat_din_wait_n1", 64'(din_wait), 64'(1));
    check("lat_we_n1", 64'(ddram_we), 64'(0));
    @(negedge clk);
    check("lat_we_n2", 64'(ddram_we), 64'(1));
    @(posedge clk);
    #1;
    din    = 8'hAA;
    din_we = 1'b1;
    start  = 1'b1;
    repeat (3) tick();
    din_we = 1'b0;
    start  = 1'b0;
    wait_idle();
    check("drop_byte_cnt", 64'(byte_cnt), 64'(PAGE_BYTES));
    check_session("drop");
    for (int j = 0; j < PAGE_BYTES; j++) send_byte(8'($urandom), 1'b0);
    wait_idle();
    check("page1_bursts", 64'(mon_bursts), 64'(2));
    check_session("page1");

    // ---- random busy during a full burst
    do_start();
    clear_counts();
    busy_rand = 1'b1;
    for (int j = 0; j < PAGE_BYTES; j++) send_byte(8'($urandom), 1'b0);
    wait_idle();
    busy_rand = 1'b0;
    check("busy_words", 64'(mon_words), 64'(128));
    check_session("busy");

    // ---- reset in the middle of a burst
    do_start();
    clear_counts();
    for (int j = 0; j < PAGE_BYTES; j++) send_byte(8'(j), 1'b0);
    begin
      int guard = 0;
      while (!ddram_we && guard < 50) begin
        tick();
        guard++;
      end
      if (!ddram_we) fail("rst_burst_start");
    end
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check("rst_we_same_cycle", 64'(ddram_we), 64'(0));
    exp_q.delete();
    model_start();
    tick();
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    tick();
    clear_counts();
    for (int j = 0; j < PAGE_BYTES; j++) send_byte(8'(j + 5), 1'b0);
    wait_idle();
    check_session("post_rst");

`ifdef JTFRAME_DDR_DUMP_CHECKSUM_EN
    do_start();
    clear_counts();
    for (int j = 0; j < 16; j++) send_byte(8'hFF, 1'b0);
    send_flush();
    wait_idle();
    check("chk_16xff", 64'(mon_chk), 64'(16'h0FF0));
`endif

    // ---- randomized sessions with gaps, busy and flush modes
    for (int r = 0; r < 6; r++) begin
      int n  = $urandom_range(1, 2600);
      int fm = $urandom_range(0, 2);
      busy_rand = $urandom_range(0, 1) == 1;
      do_start();
      clear_counts();
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 3) == 0) tick();
        send_byte(8'($urandom), fm == 2 && j == n - 1);
      end
      if (fm == 1) send_flush();
      wait_idle();
      check_session($sformatf("rand%0d", r));
`ifdef JTFRAME_DDR_DUMP_CHECKSUM_EN
      if (fm != 0) check($sformatf("rand%0d_chk", r), 64'(mon_chk), 64'(m_chk));
`endif
    end
    busy_rand = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
